// File: rtl/ddc_frame_sequencer.sv
// Double-buffered frame sequencer: fills a shadow buffer from a valid/ready
// stream and publishes whole frames atomically to PIO-facing registers.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   in_valid/in_data   sample stream; in_ready is high while filling
//   hps_read_bit       HPS acknowledge toggle (asynchronous to clk)
//   timeout_cycles     forced-publish threshold, 0 disables it
//   frame_data         published frame, word i at [i*DW +: DW]
//   frame_valid        published frame awaiting acknowledge
//   frame_seq          published-frame counter (wraps)
//   time_out           wait count captured at the last acknowledge
//   drop_count         frames replaced by timeout without ack (saturating)
module ddc_frame_sequencer #(
  parameter int NWORDS = 32,
  parameter int DW     = 32,
  parameter int TW     = 26
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [DW-1:0]      in_data,
  output logic               in_ready,
  input  logic               hps_read_bit,
  input  logic [TW-1:0]      timeout_cycles,
  output logic [NWORDS*DW-1:0] frame_data,
  output logic               frame_valid,
  output logic [15:0]        frame_seq,
  output logic [TW-1:0]      time_out,
  output logic [15:0]        drop_count
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] idx;
  logic [DW-1:0] shadow [NWORDS];
  logic          pending;
  logic [TW-1:0] wait_cnt;

  logic s1;
  logic s2;
  logic s3;
  logic ack_pulse;
  logic ack_take;
  logic timeout_hit;
  logic publish;

  assign ack_pulse   = s2 ^ s3;
  assign ack_take    = ack_pulse & pending;
  assign timeout_hit = pending
                     & (timeout_cycles != '0)
                     & (wait_cnt >= timeout_cycles);
  assign frame_valid = pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= hps_read_bit;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    publish  = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && idx == LAST) begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        publish = !pending | ack_pulse | timeout_hit;
        if (publish) begin
          state_n = FILL;
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= '0;
      pending    <= 1'b0;
      wait_cnt   <= '0;
      time_out   <= '0;
      frame_seq  <= '0;
      drop_count <= '0;
      frame_data <= '0;
      for (int i = 0; i < NWORDS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      if (in_valid && in_ready) begin
        shadow[idx] <= in_data;
        idx <= (idx == LAST) ? '0 : idx + IW'(1);
      end
      if (publish) begin
        for (int i = 0; i < NWORDS; i++) begin
          frame_data[i*DW +: DW] <= shadow[i];
        end
        frame_seq <= frame_seq + 16'd1;
        pending   <= 1'b1;
        wait_cnt  <= '0;
        // A coincident ack means the old frame was read, not dropped.
        if (timeout_hit && !ack_pulse && drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end else begin
        if (ack_take) begin
          pending <= 1'b0;
        end
        if (pending && wait_cnt != '1) begin
          wait_cnt <= wait_cnt + TW'(1);
        end
      end
      if (ack_take) begin
        time_out <= wait_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ddc_frame_sequencer.sv
// Self-checking bench for ddc_frame_sequencer: directed scenarios plus
// randomized traffic, compared every cycle against a frame-level model.
module tb_ddc_frame_sequencer;

  localparam int NW = 32;
  localparam int DW = 32;
  localparam int TW = 26;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic            hps_read_bit;
  logic [TW-1:0]   timeout_cycles;
  logic [NW*DW-1:0] frame_data;
  logic            frame_valid;
  logic [15:0]     frame_seq;
  logic [TW-1:0]   time_out;
  logic [15:0]     drop_count;

  ddc_frame_sequencer #(.NWORDS(NW), .DW(DW), .TW(TW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .hps_read_bit   (hps_read_bit),
    .timeout_cycles (timeout_cycles),
    .frame_data     (frame_data),
    .frame_valid    (frame_valid),
    .frame_seq      (frame_seq),
    .time_out       (time_out),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  int nc = 0;
  int nf = 0;
  bit chk_en = 1'b0;

  // Reference model: words collected so far, a full-buffer flag, the
  // currently published frame and the HPS-visible counters.
  int            m_cnt = 0;
  bit            m_full = 1'b0;
  logic [DW-1:0] m_buf [NW];
  logic [DW-1:0] m_frame [NW];
  bit            m_pend = 1'b0;
  logic [15:0]   m_seq = '0;
  logic [TW-1:0] m_wait = '0;
  logic [TW-1:0] m_tout = '0;
  logic [15:0]   m_drop = '0;
  logic [2:0]    hq = '0;

  always @(posedge clk or negedge reset_n) begin
    bit ack;
    bit th;
    bit pub;
    if (!reset_n) begin
      m_cnt  <= 0;
      m_full <= 1'b0;
      m_pend <= 1'b0;
      m_seq  <= '0;
      m_wait <= '0;
      m_tout <= '0;
      m_drop <= '0;
      hq     <= '0;
      for (int i = 0; i < NW; i++) m_frame[i] <= '0;
    end else begin
      // hps_read_bit is seen as an acknowledge two edges after sampling.
      ack = hq[1] ^ hq[2];
      th  = m_pend && timeout_cycles != 0
            && m_wait >= timeout_cycles;
      pub = m_full && (!m_pend || ack || th);
      if (!m_full && in_valid) begin
        m_buf[m_cnt] <= in_data;
        if (m_cnt == NW - 1) begin
          m_cnt  <= 0;
          m_full <= 1'b1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      if (pub) begin
        m_frame <= m_buf;
        m_seq   <= m_seq + 16'd1;
        m_full  <= 1'b0;
        m_pend  <= 1'b1;
        m_wait  <= '0;
        if (th && !ack && m_drop != 16'hFFFF)
          m_drop <= m_drop + 16'd1;
      end else begin
        if (ack && m_pend) m_pend <= 1'b0;
        if (m_pend && m_wait != '1) m_wait <= m_wait + 1'b1;
      end
      if (ack && m_pend) m_tout <= m_wait;
      hq <= {hq[1:0], hps_read_bit};
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return frame_data[i*DW +: DW];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NW*DW-1:0] exp_fd;
      for (int i = 0; i < NW; i++) exp_fd[i*DW +: DW] = m_frame[i];
      check("in_ready", in_ready, !m_full);
      check("frame_valid", frame_valid, m_pend);
      check("frame_seq", frame_seq, m_seq);
      check("time_out", time_out, m_tout);
      check("drop_count", drop_count, m_drop);
      nc++;
      if (frame_data !== exp_fd) begin
        nf++;
        for (int i = 0; i < NW; i++) begin
          if (frame_data[i*DW +: DW] !== exp_fd[i*DW +: DW]) begin
            $display("FAIL frame_data word %0d: got %0h expected %0h t=%0t",
                     i, frame_data[i*DW +: DW], exp_fd[i*DW +: DW], $time);
            break;
          end
        end
      end
    end
  end

  task automatic push(input logic [DW-1:0] d, input bit rnd);
    int n = 0;
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      acc = in_ready;
      if (rnd && $urandom_range(7) == 0) hps_read_bit = ~hps_read_bit;
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 3000) begin
        nc++;
        nf++;
        $display("FAIL push_stall: word %0h not accepted", d);
        break;
      end
    end
    in_valid = 1'b0;
    if (rnd) repeat ($urandom_range(2)) @(negedge clk);
  endtask

  task automatic wait_seq(input logic [15:0] s, input int budget);
    int n = 0;
    while (frame_seq != s) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        nc++;
        nf++;
        $display("FAIL wait_seq: seq %0d expected %0d", frame_seq, s);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    bit tmp_ok;
    reset_n        = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    hps_read_bit   = 1'b0;
    timeout_cycles = '0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Reset state and first frame latency.
    check("rst_valid", frame_valid, 0);
    check("rst_seq", frame_seq, 0);
    check("rst_ready", in_ready, 1);
    for (int i = 0; i < NW; i++) push(32'h100 + i, 1'b0);
    check("t1_not_yet", frame_valid, 0);
    @(negedge clk);
    check("t1_valid", frame_valid, 1);
    check("t1_seq", frame_seq, 1);
    check("t1_w0", word(0), 32'h100);
    check("t1_w31", word(31), 32'h11F);

    // No timeout, no ack: backpressure holds the second frame.
    do_reset();
    timeout_cycles = '0;
    for (int i = 0; i < 2 * NW; i++) push(32'h1000 + i, 1'b0);
    repeat (50) @(negedge clk);
    check("t2_ready", in_ready, 0);
    check("t2_seq", frame_seq, 1);
    check("t2_drop", drop_count, 0);
    check("t2_w5", word(5), 32'h1005);

    // Acknowledge releases the held frame.
    hps_read_bit = ~hps_read_bit;
    wait_seq(16'd2, 10);
    check("t3_seq", frame_seq, 2);
    check("t3_ready", in_ready, 1);
    check("t3_w0", word(0), 32'h1020);
    tmp_ok = (time_out >= 50);
    check("t3_tout_min", tmp_ok, 1);

    // Timeout forces publication and counts a drop.
    do_reset();
    timeout_cycles = 26'd1000;
    for (int i = 0; i < 2 * NW; i++) push(32'h2000 + i, 1'b0);
    wait_seq(16'd2, 1200);
    check("t4_drop", drop_count, 1);
    check("t4_valid", frame_valid, 1);
    check("t4_w31", word(31), 32'h203F);

    // Ack coinciding with the timeout publish is not a drop.
    for (int i = 0; i < NW; i++) push(32'h3000 + i, 1'b0);
    for (int n = 0; n < 1200 && m_wait != 26'd998; n++) @(negedge clk);
    hps_read_bit = ~hps_read_bit;
    wait_seq(16'd3, 10);
    check("t5_drop", drop_count, 1);
    check("t5_valid", frame_valid, 1);
    check("t5_tout", time_out, 1000);

    // Reset mid-fill discards the partial frame.
    do_reset();
    timeout_cycles = '0;
    for (int i = 0; i < 10; i++) push(32'hDEAD0000 + i, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", frame_valid, 0);
    check("t6_rst_seq", frame_seq, 0);
    check("t6_rst_data", (frame_data == '0), 1);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NW; i++) push(32'h200 + i, 1'b0);
    repeat (2) @(negedge clk);
    check("t6_seq", frame_seq, 1);
    check("t6_w0", word(0), 32'h200);
    check("t6_w31", word(31), 32'h21F);

    // Randomized traffic with random acks and timeouts.
    do_reset();
    for (int f = 0; f < 20; f++) begin
      timeout_cycles = TW'($urandom_range(80, 10));
      for (int i = 0; i < NW; i++) push($urandom, 1'b1);
    end
    repeat (100) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
